// File: rtl/demux1_4.sv
// demux1_4: registered 1-to-4 packet demultiplexer.
// A single valid/ready input stream is routed to channel a/b/c/d by {s0,s1}
// (00->a, 01->b, 10->c, 11->d). The channel is locked on the first beat of a
// packet and held until the beat carrying in_last.
// Each channel has a one-entry output buffer.
// Optional feature: define DEMUX_COUNT_EN to enable the per-channel
// delivered-beat counters. Without it, the x_cnt ports are tied to zero.
module demux1_4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s0,
  input  logic         s1,
  output logic [W-1:0] a_data,
  output logic [W-1:0] b_data,
  output logic [W-1:0] c_data,
  output logic [W-1:0] d_data,
  output logic         a_last,
  output logic         b_last,
  output logic         c_last,
  output logic         d_last,
  output logic         a_valid,
  output logic         b_valid,
  output logic         c_valid,
  output logic         d_valid,
  input  logic         a_ready,
  input  logic         b_ready,
  input  logic         c_ready,
  input  logic         d_ready,
  output logic [7:0]   a_cnt,
  output logic [7:0]   b_cnt,
  output logic [7:0]   c_cnt,
  output logic [7:0]   d_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [1:0]          lch_q, lch_d;
  logic [3:0]          vld_q, vld_d;
  logic [3:0]          last_q, last_d;
  logic [3:0][W-1:0]   data_q, data_d;

  logic [3:0]          rdy_vec;
  logic [3:0]          xfer;
  logic [1:0]          tgt;
  logic                accept;

  assign rdy_vec = {d_ready, c_ready, b_ready, a_ready};
  assign xfer    = vld_q & rdy_vec;

  // Target selection, input handshake, FSM next state and buffer next state
  always_comb begin
    state_d = state_q;
    lch_d   = lch_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;

    tgt      = (state_q == IDLE) ? {s0, s1} : lch_q;
    in_ready = !vld_q[tgt] | rdy_vec[tgt];
    accept   = in_valid & in_ready;

    unique case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = BURST;
          lch_d   = {s0, s1};
        end
      end
      BURST: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < 4; i++) begin
      if (accept && (tgt == 2'(i))) begin
        vld_d[i]  = 1'b1;
        data_d[i] = in_data;
        last_d[i] = in_last;
      end else if (xfer[i]) begin
        vld_d[i]  = 1'b0;
      end
    end
  end

  // State and output buffer registers; reset overrides any accept/transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lch_q   <= '0;
      vld_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lch_q   <= lch_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign {d_valid, c_valid, b_valid, a_valid} = vld_q;
  assign {d_last,  c_last,  b_last,  a_last}  = last_q;
  assign a_data = data_q[0];
  assign b_data = data_q[1];
  assign c_data = data_q[2];
  assign d_data = data_q[3];

`ifdef DEMUX_COUNT_EN
  logic [3:0][7:0] cnt_q, cnt_d;

  // Delivered-beat counters, wrapping naturally at 255
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign a_cnt = cnt_q[0];
  assign b_cnt = cnt_q[1];
  assign c_cnt = cnt_q[2];
  assign d_cnt = cnt_q[3];
`else
  assign a_cnt = '0;
  assign b_cnt = '0;
  assign c_cnt = '0;
  assign d_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1_4.sv
// Directed testbench for demux1_4 with hand-computed expected values.
module tb_demux1_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_last, in_valid, in_ready;
  logic       s0, s1;
  logic [7:0] a_data, b_data, c_data, d_data;
  logic       a_last, b_last, c_last, d_last;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  demux1_4 #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1),
    .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
    .a_last(a_last), .b_last(b_last), .c_last(c_last), .d_last(d_last),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
    in_valid = v;
    {s0, s1} = sel;
    in_data  = d;
    in_last  = l;
  endtask

  function automatic logic [3:0] vvec();
    return {d_valid, c_valid, b_valid, a_valid};
  endfunction

  logic [7:0] exp_data [4];
  logic [1:0] sel;

  initial begin
    rst = 1'b1;
    {a_ready, b_ready, c_ready, d_ready} = 4'b1111;
    drive(1'b0, 2'b00, 8'h00, 1'b0);

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(vvec()), 32'h0);
    check("rst_cnt", {a_cnt, b_cnt, c_cnt, d_cnt}, 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_data", {a_data, b_data, c_data, d_data}, 32'h0);

    // Single-beat routing to each channel
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), exp_data[k], 1'b1);
      tick();
      check($sformatf("single_vld%0d", k), 32'(vvec()), 32'h1 << k);
      case (k)
        0: check("single_a_data", 32'(a_data), 32'h11);
        1: check("single_b_data", 32'(b_data), 32'h22);
        2: check("single_c_data", 32'(c_data), 32'h33);
        default: check("single_d_data", 32'(d_data), 32'h44);
      endcase
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      tick();
      check($sformatf("single_clr%0d", k), 32'(vvec()), 32'h0);
    end

    // Burst lock: select toggles after the first beat, packet stays on c
    sel = 2'b10;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sel, 8'hA0 + 8'(i), (i == 3));
      tick();
      check($sformatf("burst_vld%0d", i), 32'(vvec()), 32'h4);
      check($sformatf("burst_data%0d", i), 32'(c_data), 32'hA0 + 32'(i));
      check($sformatf("burst_last%0d", i), 32'(c_last), (i == 3) ? 32'h1 : 32'h0);
      sel = ~sel;
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 2'b00, 8'h5A, 1'b1);
    tick();
    check("burst_idle_route", 32'(vvec()), 32'h1);
    check("burst_idle_data", 32'(a_data), 32'h5A);
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();

    // Backpressure on b
    b_ready = 1'b0;
    drive(1'b1, 2'b01, 8'hB0, 1'b0);
    #1;
    check("bp_ready0", 32'(in_ready), 32'h1);
    tick();
    check("bp_held_vld", 32'(b_valid), 32'h1);
    check("bp_held_data", 32'(b_data), 32'hB0);
    drive(1'b1, 2'b01, 8'hB1, 1'b1);
    #1;
    check("bp_ready1", 32'(in_ready), 32'h0);
    tick();
    check("bp_noloss", 32'(b_data), 32'hB0);
    check("bp_noloss_last", 32'(b_last), 32'h0);
    b_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_second_vld", 32'(b_valid), 32'h1);
    check("bp_second_data", 32'(b_data), 32'hB1);
    check("bp_second_last", 32'(b_last), 32'h1);
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();
    check("bp_drained", 32'(vvec()), 32'h0);

    // Independence: b stalled, d keeps delivering; then reset mid-burst
    b_ready = 1'b0;
    drive(1'b1, 2'b01, 8'hC0, 1'b1);
    tick();
    drive(1'b1, 2'b11, 8'hD0, 1'b0);
    #1;
    check("ind_ready", 32'(in_ready), 32'h1);
    tick();
    check("ind_both_vld", 32'(vvec()), 32'hA);
    check("ind_d_data", 32'(d_data), 32'hD0);
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();
    check("ind_d_drained", 32'(vvec()), 32'h2);
    check("ind_b_held", 32'(b_data), 32'hC0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_vld", 32'(vvec()), 32'h0);
    check("rst_mid_data", 32'(b_data), 32'h0);
    b_ready = 1'b1;
    drive(1'b1, 2'b00, 8'hE0, 1'b1);
    tick();
    check("rst_new_route", 32'(vvec()), 32'h1);
    check("rst_new_data", 32'(a_data), 32'hE0);
    drive(1'b0, 2'b00, 8'h00, 1'b0);

    // Counter wrap: 257 beats to a after a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 2'b00, 8'h01, 1'b1);
    for (int i = 0; i < 257; i++) begin
      tick();
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();
`ifdef DEMUX_COUNT_EN
    check("cnt_a_wrap", 32'(a_cnt), 32'h1);
`else
    check("cnt_a_tied", 32'(a_cnt), 32'h0);
`endif
    check("cnt_others", {8'h0, b_cnt, c_cnt, d_cnt}, 32'h0);
    check("cnt_final_vld", 32'(vvec()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_4.md
# demux1_4

Registered 1-to-4 demultiplexer. It is the receive-side counterpart of the 4:1 select mux used on the datapath. It accepts beats on a single valid/ready input stream and routes each packet to one of four output channels a, b, c, d, chosen by s0/s1. The select encoding matches the mux: {s0,s1}=00→a, 01→b, 10→c, 11→d. The channel is latched on the first beat of a packet and held until the beat carrying in_last, so packets are never split across channels.

## Interface
- W, 8: data width in bits (≥1).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  W  input beat payload.
- in_last  in  1  marks the final beat of a packet.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept the beat this cycle.
- s0, s1  in  1 each  channel select; sampled only on the first beat of a packet.
- a_data, b_data, c_data, d_data  out  W each  channel payload (registered).
- a_last, b_last, c_last, d_last  out  1 each  channel last flag (registered).
- a_valid, b_valid, c_valid, d_valid  out  1 each  channel beat present (registered).
- a_ready, b_ready, c_ready, d_ready  in  1 each  downstream accepts the channel beat.
- a_cnt, b_cnt, c_cnt, d_cnt  out  8 each  per-channel delivered-beat counters (see Configuration).

## Operation
- Each channel has a one-entry output buffer holding data, last and valid.
- Transfer on a channel occurs when x_valid & x_ready. An input transfer occurs when in_valid & in_ready.
- Target channel t:
  - IDLE: t = {s0,s1}.
  - BURST: t = the latched channel lch.
- in_ready = !t_valid | t_ready. This is combinational in the downstream ready and never depends on in_valid.
- On an accepted input beat, channel t's buffer loads in_data/in_last and sets t_valid = 1.
- When a channel transfers with no new load, that channel's valid clears. A simultaneous transfer and load keeps valid = 1 with the new contents, giving full throughput.
- FSM, 2 states:
  - IDLE → BURST: accepted beat with in_last=0; lch ← {s0,s1}.
  - IDLE → IDLE: no accept, or accepted beat with in_last=1 (single-beat packet).
  - BURST → IDLE: accepted beat with in_last=1.
  - BURST → BURST: otherwise. s0/s1 are ignored in BURST.
- Non-target channels keep draining independently, so a stalled channel never blocks delivery of other channels' buffered beats.
- Data registers load only on accept and are not cleared when a beat is consumed.

## Timing
- Latency: a beat accepted at edge N is visible on x_data/x_valid after edge N, so it is available for transfer in cycle N+1.
- Throughput: 1 beat/cycle while the target's ready is held high.
- Reset values: all x_valid = 0, x_data = 0, x_last = 0, x_cnt = 0, FSM = IDLE, lch = 0. in_ready therefore = 1 after reset.
- Reset mid-packet: buffered beats are discarded, FSM returns to IDLE, and the next accepted beat samples s0/s1 afresh.
- Reset has priority over any simultaneous accept or transfer in the same cycle.
- Select changes while in_valid=1 and in_ready=0 in IDLE: the target follows the new select. Upstream must hold s0/s1 stable with in_valid.

## Configuration
- DEMUX_COUNT_EN defined:
  - x_cnt increments by 1 on each channel transfer (x_valid & x_ready).
  - Counters wrap 255→0 and clear on rst.
- DEMUX_COUNT_EN undefined:
  - Counter logic is not compiled.
  - x_cnt ports remain present and are tied to 0.
  - Routing behaviour is identical.

## Test plan
- Reset then idle: after rst=1 for 2 cycles, expect all x_valid=0, x_cnt=0, in_ready=1.
- Single-beat routing: send in_data=8'h11/22/33/44 with last=1 and {s0,s1}=00/01/10/11, all readies high. Expect a_data=11, b_data=22, c_data=33, d_data=44, each valid exactly one cycle after its accept.
- Burst lock: {s0,s1}=10 on beat 1 of a 4-beat packet (A0..A3), then s0/s1 toggled on every following beat. Expect all four beats on c in order, c_last=1 only on A3, and FSM back in IDLE.
- Backpressure: b_ready=0 with 2 beats sent to b. Expect the first held on b, in_ready=0 for the second, and no loss. Release b_ready: both beats delivered in consecutive cycles.
- Independence plus reset: b stalled with a beat held, then a beat sent to d. Expect d to deliver while b holds. Assert rst mid-burst: expect all valid=0 and IDLE. A new packet then uses the new select.
- Counter wrap (DEMUX_COUNT_EN): deliver 257 beats to a. Expect a_cnt=1 and other counters 0. Without the macro, all x_cnt stay 0.
